// File: rtl/edge_burst_gen_pkg.sv
// Shared definitions for the edge burst generator: state encoding and default widths.
package edge_burst_gen_pkg;

    localparam int DEF_CNT_W = 4;
    localparam int DEF_GAP_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/edge_burst_gen_gap_timer.sv
// Loadable down-counter that sets the spacing between toggles; it never wraps below zero.
module edge_burst_gen_gap_timer #(
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [GAP_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [GAP_W-1:0] o_value,
    output logic             o_zero
);

    logic [GAP_W-1:0] r_value;

    // Load has priority over decrement; decrement only while nonzero.
    always_ff @(posedge clk) begin
        if (reset)
            r_value <= '0;
        else if (i_load)
            r_value <= i_load_val;
        else if (i_dec && (r_value != '0))
            r_value <= r_value - GAP_W'(1);
    end

    assign o_value = r_value;
    assign o_zero  = (r_value == '0);

endmodule

// File: rtl/edge_burst_gen.sv
// Emits a burst of 'count' level toggles on sig, spaced gap+1 cycles apart, then pulses done.
// start/count/gap are captured into a request register one edge before the burst begins.
module edge_burst_gen
    import edge_burst_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [GAP_W-1:0] gap,
    output logic             sig,
    output logic             edgeStrobe,
    output logic             busy,
    output logic             done
);

    state_t           r_state, w_state_nxt;
    logic             r_req;
    logic [CNT_W-1:0] r_cnt_lat;
    logic [GAP_W-1:0] r_gap_lat;
    logic [CNT_W-1:0] r_remaining, w_rem_nxt;
    logic             r_sig, w_sig_nxt;
    logic             r_strobe, w_strobe_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             w_load, w_dec, w_gap_zero;
    logic [GAP_W-1:0] w_gap_value;

    // Capture a request only while idle with nothing pending; count/gap frozen until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req     <= 1'b0;
            r_cnt_lat <= '0;
            r_gap_lat <= '0;
        end else if ((r_state == S_IDLE) && !r_req && start) begin
            r_req     <= 1'b1;
            r_cnt_lat <= count;
            r_gap_lat <= gap;
        end else begin
            r_req     <= 1'b0;
        end
    end

    edge_burst_gen_gap_timer #(.GAP_W(GAP_W)) u_gap (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (r_gap_lat),
        .i_dec      (w_dec),
        .o_value    (w_gap_value),
        .o_zero     (w_gap_zero)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt  = r_state;
        w_sig_nxt    = r_sig;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_rem_nxt    = r_remaining;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_req) begin
                    if (r_cnt_lat != '0) begin
                        w_sig_nxt    = ~r_sig;
                        w_strobe_nxt = 1'b1;
                        w_rem_nxt    = r_cnt_lat - CNT_W'(1);
                        w_load       = 1'b1;
                        w_state_nxt  = S_WAIT;
                    end else begin
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (!w_gap_zero) begin
                    w_dec = 1'b1;
                end else if (r_remaining != '0) begin
                    w_sig_nxt    = ~r_sig;
                    w_strobe_nxt = 1'b1;
                    w_rem_nxt    = r_remaining - CNT_W'(1);
                    w_load       = 1'b1;
                end else begin
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State, toggle counter and registered outputs; reset abandons any burst and forces sig low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_sig       <= 1'b0;
            r_strobe    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_rem_nxt;
            r_sig       <= w_sig_nxt;
            r_strobe    <= w_strobe_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign sig        = r_sig;
    assign edgeStrobe = r_strobe;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_edge_burst_gen.sv
// Directed bench for edge_burst_gen: burst table, held start, mid-burst reset, edge-detector loopback.
module tb_edge_burst_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] count;
    logic [7:0] gap;
    logic       sig, edgeStrobe, busy, done;

    int checks = 0;
    int failures = 0;

    edge_burst_gen #(.CNT_W(4), .GAP_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .count      (count),
        .gap        (gap),
        .sig        (sig),
        .edgeStrobe (edgeStrobe),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Dual-edge Moore detector fed from sig: anyEdge is high the cycle after sig changes.
    logic d_prev, d_any;
    always @(posedge clk) begin
        if (reset) begin
            d_prev <= 1'b0;
            d_any  <= 1'b0;
        end else begin
            d_prev <= sig;
            d_any  <= (sig != d_prev);
        end
    end

    typedef struct {
        int    cnt;
        int    gp;
        int    done_at;
        int    ntog;
        logic  fin;
        logic  hold;
        string name;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic m_sig;
    int   n_strobe;
    int   n_any;
    logic prev_strobe;

    initial begin
        vecs[0] = '{cnt: 3,  gp: 2,   done_at: 10,   ntog: 3,  fin: 1'b1, hold: 1'b0, name: "c3g2"};
        vecs[1] = '{cnt: 2,  gp: 0,   done_at: 3,    ntog: 2,  fin: 1'b1, hold: 1'b1, name: "c2g0_hold"};
        vecs[2] = '{cnt: 0,  gp: 5,   done_at: 1,    ntog: 0,  fin: 1'b1, hold: 1'b0, name: "c0g5"};
        vecs[3] = '{cnt: 1,  gp: 0,   done_at: 2,    ntog: 1,  fin: 1'b0, hold: 1'b0, name: "c1g0"};
        vecs[4] = '{cnt: 4,  gp: 1,   done_at: 9,    ntog: 4,  fin: 1'b0, hold: 1'b0, name: "c4g1"};
        vecs[5] = '{cnt: 15, gp: 255, done_at: 3841, ntog: 15, fin: 1'b1, hold: 1'b0, name: "c15g255"};

        reset = 1'b1; start = 1'b0; count = '0; gap = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_sig", sig, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_strobe", edgeStrobe, 0);

        // Idle with no request: all outputs stay low.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_outs", {sig, busy, done, edgeStrobe}, 0);
        end

        m_sig = 1'b0;
        for (int v = 0; v < 6; v++) begin
            start = 1'b1;
            count = 4'(vecs[v].cnt);
            gap   = 8'(vecs[v].gp);
            tick();                                 // edge k: request captured
            chk({vecs[v].name, "_k_busy"}, busy, 0);
            if (!vecs[v].hold) start = 1'b0;
            count = 4'hF;                           // later changes must be ignored
            gap   = 8'h00;
            n_strobe = 0;
            for (int j = 1; j <= vecs[v].done_at + 1; j++) begin
                tick();
                begin
                    logic es;
                    es = (j < vecs[v].done_at) && (((j - 1) % (vecs[v].gp + 1)) == 0);
                    if (es) m_sig = ~m_sig;
                    if (edgeStrobe) n_strobe++;
                    chk({vecs[v].name, "_strobe"}, edgeStrobe, es);
                    chk({vecs[v].name, "_done"}, done, (j == vecs[v].done_at));
                    chk({vecs[v].name, "_busy"}, busy, (j <= vecs[v].done_at));
                    chk({vecs[v].name, "_sig"}, sig, m_sig);
                end
            end
            start = 1'b0;
            chk({vecs[v].name, "_ntog"}, n_strobe, vecs[v].ntog);
            chk({vecs[v].name, "_final"}, sig, vecs[v].fin);
            tick();
            chk({vecs[v].name, "_idle_after"}, {busy, done, edgeStrobe}, 0);
        end

        // Reset mid-burst: sig is 1 after 4 toggles (1,257,513,769) from an idle level of 1.
        start = 1'b1; count = 4'd15; gap = 8'd255;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 1000; j++) tick();
        chk("midrst_pre_sig", sig, 1);
        chk("midrst_pre_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_sig", sig, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_strobe", edgeStrobe, 0);
        for (int j = 0; j < 300; j++) begin
            tick();
            chk("midrst_quiet", {sig, busy, done, edgeStrobe}, 0);
        end

        // Loopback: count=5, gap=3 gives toggles at 1,5,9,13,17 and done at 21.
        start = 1'b1; count = 4'd5; gap = 8'd3;
        tick();
        start = 1'b0;
        n_any = 0;
        prev_strobe = 1'b0;
        for (int j = 1; j <= 24; j++) begin
            tick();
            if (d_any) n_any++;
            chk("loop_any_follows_strobe", d_any, prev_strobe);
            chk("loop_strobe", edgeStrobe, (j < 21) && (((j - 1) % 4) == 0));
            prev_strobe = edgeStrobe;
        end
        chk("loop_any_count", n_any, 5);
        chk("loop_final_sig", sig, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
